result_formatter: RTL and testbench



---
 rtl/result_formatter.sv | 179 +++++++++++++++++
 tb/tb_result_formatter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/result_formatter.sv
// result_formatter
// Renders a 32-bit result as a packed ASCII decimal string terminated by "\n".
// The conversion runs in stages:
//   SHIFT - 32 rounds of double-dabble (add-3 then shift) build 10 BCD digits
//   STRIP - walk down from the top digit past leading zeros
//   SIGN  - optional '-' for negative signed inputs
//   EMIT  - one ASCII digit per cycle, most significant first
//   TERM  - newline, one-cycle done pulse, back to IDLE
// Character k of the output lives at str[255-8k -: 8], so char 0 is at the MSB end.

module result_formatter #(
    parameter bit SIGNED = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [31:0]  value,
    output logic [255:0] str,
    output logic         busy,
    output logic         done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        STRIP = 3'd2,
        SIGN  = 3'd3,
        EMIT  = 3'd4,
        TERM  = 3'd5
    } state_t;

    localparam logic [7:0] CHAR_MINUS = 8'h2D;
    localparam logic [7:0] CHAR_ZERO  = 8'h30;
    localparam logic [7:0] CHAR_NL    = 8'h0A;

    state_t       state_reg;
    logic [39:0]  bcd_reg;      // 10 BCD digits, digit 0 in bits [3:0]
    logic [31:0]  mag_reg;      // magnitude being shifted into the BCD register
    logic [5:0]   cnt_reg;      // shift round counter
    logic [3:0]   digit_reg;    // current digit index d (9 = most significant)
    logic [4:0]   ptr_reg;      // next character position p
    logic         neg_reg;      // value was negative (signed build only)

    // Combinational helpers
    logic [39:0]  bcd_adj;      // BCD after the add-3 correction of this round
    logic [39:0]  bcd_shifted;  // BCD after the shift of this round
    logic [3:0]   digit [10];   // digit view of the BCD register
    logic [3:0]   digit_dec;    // d - 1, the index STRIP looks at next
    logic [3:0]   cur_digit;    // digit[d]
    logic [3:0]   next_digit;   // digit[d-1]
    logic         lead_nonzero; // top digit of the freshly shifted BCD is non-zero
    state_t       out_state;    // first output state once the leading digit is found

    genvar gi;

    // Per-nibble add-3 correction and digit unpacking
    generate
        for (gi = 0; gi < 10; gi++) begin : g_digit
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5)
                                      ? (bcd_reg[4*gi +: 4] + 4'd3)
                                      :  bcd_reg[4*gi +: 4];
            assign digit[gi] = bcd_reg[4*gi +: 4];
        end
    endgenerate

    assign bcd_shifted  = {bcd_adj[38:0], mag_reg[31]};
    assign lead_nonzero = (bcd_shifted[39:36] != 4'd0);
    assign digit_dec    = digit_reg - 4'd1;
    assign out_state    = neg_reg ? SIGN : EMIT;

    // Select the digit at the current index and at the next-lower index
    always_comb begin
        cur_digit  = 4'd0;
        next_digit = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (digit_reg == k[3:0]) begin
                cur_digit = digit[k];
            end
            if (digit_dec == k[3:0]) begin
                next_digit = digit[k];
            end
        end
    end

    // Returns s with the character at position pos replaced by c
    function automatic logic [255:0] put_char(input logic [255:0] s,
                                              input logic [4:0]   pos,
                                              input logic [7:0]   c);
        logic [255:0] r;
        r = s;
        for (int k = 0; k < 32; k++) begin
            if (pos == k[4:0]) begin
                r[255 - 8*k -: 8] = c;
            end
        end
        return r;
    endfunction

    // Control FSM, datapath and registered outputs.
    // STRIP looks one digit ahead so that the leading-zero walk costs exactly
    // one cycle per stripped zero, which keeps the total latency constant per sign.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            bcd_reg   <= '0;
            mag_reg   <= '0;
            cnt_reg   <= '0;
            digit_reg <= '0;
            ptr_reg   <= '0;
            neg_reg   <= 1'b0;
            str       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        neg_reg   <= SIGNED && value[31];
                        mag_reg   <= (SIGNED && value[31]) ? (~value + 32'd1) : value;
                        str       <= '0;
                        busy      <= 1'b1;
                        cnt_reg   <= '0;
                        bcd_reg   <= '0;
                        ptr_reg   <= '0;
                        digit_reg <= 4'd9;
                        state_reg <= SHIFT;
                    end
                end

                SHIFT: begin
                    bcd_reg <= bcd_shifted;
                    mag_reg <= {mag_reg[30:0], 1'b0};
                    cnt_reg <= cnt_reg + 6'd1;
                    if (cnt_reg == 6'd31) begin
                        digit_reg <= 4'd9;
                        state_reg <= lead_nonzero ? out_state : STRIP;
                    end
                end

                STRIP: begin
                    // digit[d] is known to be zero here; step down one place
                    digit_reg <= digit_dec;
                    if ((digit_dec == 4'd0) || (next_digit != 4'd0)) begin
                        state_reg <= out_state;
                    end
                end

                SIGN: begin
                    str[255 -: 8] <= CHAR_MINUS;
                    ptr_reg       <= 5'd1;
                    state_reg     <= EMIT;
                end

                EMIT: begin
                    str     <= put_char(str, ptr_reg, CHAR_ZERO + {4'd0, cur_digit});
                    ptr_reg <= ptr_reg + 5'd1;
                    if (digit_reg == 4'd0) begin
                        state_reg <= TERM;
                    end else begin
                        digit_reg <= digit_reg - 4'd1;
                    end
                end

                TERM: begin
                    str       <= put_char(str, ptr_reg, CHAR_NL);
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_formatter.sv
// Testbench for result_formatter: a signed and an unsigned instance run side by
// side on the same stimulus. Table vectors, randomized values against a decimal
// reference model, and hand-written handshake and reset sequences.

module tb_result_formatter;

    logic         clk;
    logic         rst;
    logic         start;
    logic [31:0]  value;
    logic [255:0] str_s, str_u;
    logic         busy_s, busy_u;
    logic         done_s, done_u;

    int n_cmp;
    int n_bad;

    result_formatter #(.SIGNED(1'b1)) u_signed (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .str(str_s), .busy(busy_s), .done(done_s)
    );

    result_formatter #(.SIGNED(1'b0)) u_unsigned (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .str(str_u), .busy(busy_u), .done(done_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] value;
        string       exp_s;
        string       exp_u;
        int          lat_s;
    } vec_t;

    vec_t tbl [6];

    // Expected string from literal text plus the terminating newline
    function automatic logic [255:0] pack(input string s);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < s.len(); i++) begin
            r[255 - 8*i -: 8] = s[i];
        end
        r[255 - 8*s.len() -: 8] = 8'h0A;
        return r;
    endfunction

    // Reference model: decimal rendering by repeated division
    function automatic logic [255:0] model(input logic [31:0] v, input bit sgn);
        logic [255:0]    r;
        bit              neg;
        longint unsigned m;
        byte unsigned    digs [12];
        int              nd;
        int              pos;
        r   = '0;
        nd  = 0;
        pos = 0;
        neg = sgn && v[31];
        m   = neg ? (64'd4294967296 - {32'd0, v}) : {32'd0, v};
        do begin
            digs[nd] = 8'(m % 10) + 8'd48;
            m = m / 10;
            nd++;
        end while (m != 0);
        if (neg) begin
            r[255 -: 8] = 8'h2D;
            pos = 1;
        end
        for (int i = nd - 1; i >= 0; i--) begin
            r[255 - 8*pos -: 8] = digs[i];
            pos++;
        end
        r[255 - 8*pos -: 8] = 8'h0A;
        return r;
    endfunction

    task automatic check_vec(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // One full transaction on both instances, with latency/pulse/stability checks
    task automatic do_xact(input logic [31:0] v, input logic [255:0] exp_s,
                           input logic [255:0] exp_u, input int lat_s, input string tag);
        int           done_s_at, done_u_at, done_s_cnt, done_u_cnt, busy_cnt;
        logic [255:0] s_at_done, u_at_done;
        done_s_at  = -1;
        done_u_at  = -1;
        done_s_cnt = 0;
        done_u_cnt = 0;
        busy_cnt   = 0;
        s_at_done  = '0;
        u_at_done  = '0;
        @(negedge clk);
        start = 1'b1;
        value = v;
        @(posedge clk);                  // accepting edge E0
        @(negedge clk);
        start = 1'b0;
        value = $urandom;                // value may change after acceptance
        if (busy_s) busy_cnt++;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (busy_s) busy_cnt++;
            if (done_s) begin
                done_s_cnt++;
                if (done_s_at < 0) begin
                    done_s_at = k;
                    s_at_done = str_s;
                end
            end
            if (done_u) begin
                done_u_cnt++;
                if (done_u_at < 0) begin
                    done_u_at = k;
                    u_at_done = str_u;
                end
            end
        end
        check_int({tag, " latency_s"}, done_s_at, lat_s);
        check_int({tag, " latency_u"}, done_u_at, 43);
        check_int({tag, " pulses_s"}, done_s_cnt, 1);
        check_int({tag, " pulses_u"}, done_u_cnt, 1);
        check_int({tag, " busy_cycles_s"}, busy_cnt, lat_s);
        check_vec({tag, " str_s"}, s_at_done, exp_s);
        check_vec({tag, " str_u"}, u_at_done, exp_u);
        check_vec({tag, " str_s_stable"}, str_s, exp_s);
        $display("xact %s value=%h signed_done@%0d unsigned_done@%0d str_s=%h",
                 tag, v, done_s_at, done_u_at, s_at_done[255:160]);
    endtask

    initial begin
        logic [31:0] rv;
        int          pulses;
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        start = 1'b0;
        value = '0;

        tbl[0] = '{32'd0,          "0",           "0",          43};
        tbl[1] = '{32'd12345,      "12345",       "12345",      43};
        tbl[2] = '{32'hFFFFFFF9,   "-7",          "4294967289", 44};
        tbl[3] = '{32'h80000000,   "-2147483648", "2147483648", 44};
        tbl[4] = '{32'hFFFFFFFF,   "-1",          "4294967295", 44};
        tbl[5] = '{32'h7FFFFFFF,   "2147483647",  "2147483647", 43};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_vec("reset str_s", str_s, '0);
        check_int("reset busy_s", int'(busy_s), 0);
        check_int("reset done_s", int'(done_s), 0);
        check_int("reset busy_u", int'(busy_u), 0);
        rst = 1'b0;

        // Table-driven vectors
        foreach (tbl[i]) begin
            do_xact(tbl[i].value, pack(tbl[i].exp_s), pack(tbl[i].exp_u),
                    tbl[i].lat_s, $sformatf("tbl%0d", i));
        end

        // Randomized values against the reference model
        for (int i = 0; i < 16; i++) begin
            case (i % 4)
                0:       rv = $urandom;
                1:       rv = $urandom_range(0, 999);
                2:       rv = 32'd0 - $urandom_range(1, 100000);
                default: rv = $urandom | 32'h80000000;
            endcase
            do_xact(rv, model(rv, 1'b1), model(rv, 1'b0), 43 + int'(rv[31]),
                    $sformatf("rand%0d", i));
        end

        // Handshake: start held high from E0 with a new value; busy start ignored,
        // start during done rejected, next accept at E0+44
        @(negedge clk);
        start = 1'b1;
        value = 32'd5;
        @(posedge clk);
        @(negedge clk);
        value  = 32'd9;
        pulses = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (done_s) pulses++;
            if (k == 42) check_int("hs done_before", int'(done_s), 0);
            if (k == 43) begin
                check_int("hs done_at_43", int'(done_s), 1);
                check_int("hs busy_at_43", int'(busy_s), 0);
                check_vec("hs str_5", str_s, pack("5"));
                check_vec("hs str_u_5", str_u, pack("5"));
            end
            if (k == 44) begin
                check_int("hs reaccept_busy", int'(busy_s), 1);
                check_int("hs reaccept_done", int'(done_s), 0);
                check_vec("hs str_cleared", str_s, '0);
                start = 1'b0;
            end
            if (k == 87) begin
                check_int("hs done_second", int'(done_s), 1);
                check_vec("hs str_9", str_s, pack("9"));
            end
        end
        check_int("hs pulse_count", pulses, 2);
        $display("xact handshake value=5 then 9 pulses=%0d", pulses);

        // Asynchronous reset in the middle of SHIFT
        @(negedge clk);
        start = 1'b1;
        value = 32'd123456;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check_int("rst busy_before", int'(busy_s), 1);
        #1 rst = 1'b1;
        #1;
        check_int("rst busy_s_now", int'(busy_s), 0);
        check_int("rst busy_u_now", int'(busy_u), 0);
        check_vec("rst str_now", str_s, '0);
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done_s || done_u) pulses++;
        end
        check_int("rst no_done", pulses, 0);
        rst = 1'b0;
        $display("xact reset mid-shift value=123456 aborted");
        do_xact(32'd100, pack("100"), pack("100"), 43, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
